// File: rtl/escrita_reg_arbitro_if.sv
// Write-back request/grant bundle between the execute/memory sources and the
// register-file write-port arbiter.
interface escrita_reg_arbitro_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6
);
    logic                  alu_valid;
    logic                  alu_ready;
    logic [1:0]            alu_dst;
    logic [ADDR_WIDTH-1:0] alu_rt;
    logic [ADDR_WIDTH-1:0] alu_rd;
    logic [DATA_WIDTH-1:0] alu_dado;

    logic                  mem_valid;
    logic                  mem_ready;
    logic [ADDR_WIDTH-1:0] mem_rt;
    logic [DATA_WIDTH-1:0] mem_dado;

    logic [ADDR_WIDTH-1:0] reg_rt;
    logic [ADDR_WIDTH-1:0] reg_rd;
    logic [ADDR_WIDTH-1:0] reg_ra;
    logic                  selecao1;
    logic                  selecao2;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_dado;

    modport master (
        output alu_valid, alu_dst, alu_rt, alu_rd, alu_dado,
        output mem_valid, mem_rt, mem_dado,
        input  alu_ready, mem_ready,
        input  reg_rt, reg_rd, reg_ra, selecao1, selecao2, wr_en, wr_dado
    );

    modport slave (
        input  alu_valid, alu_dst, alu_rt, alu_rd, alu_dado,
        input  mem_valid, mem_rt, mem_dado,
        output alu_ready, mem_ready,
        output reg_rt, reg_rd, reg_ra, selecao1, selecao2, wr_en, wr_dado
    );
endinterface

// File: rtl/escrita_reg_arbitro.sv
// Register-file write-port arbiter: one holding slot per source (ALU, load return),
// one registered write per cycle. Define ESCRITA_RR_EN for round-robin on conflict.
module escrita_reg_arbitro #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                 clock,
    input  logic                 reset,
    escrita_reg_arbitro_if.slave bus
);
    localparam logic [1:0] DST_RT   = 2'b00;
    localparam logic [1:0] DST_RD   = 2'b01;
    localparam logic [1:0] DST_RA   = 2'b10;
    localparam logic [1:0] DST_NONE = 2'b11;

    logic                  alu_vld_p0;
    logic [1:0]            alu_dst_p0;
    logic [ADDR_WIDTH-1:0] alu_rt_p0;
    logic [ADDR_WIDTH-1:0] alu_rd_p0;
    logic [DATA_WIDTH-1:0] alu_dado_p0;

    logic                  mem_vld_p0;
    logic [ADDR_WIDTH-1:0] mem_rt_p0;
    logic [DATA_WIDTH-1:0] mem_dado_p0;

    logic                  wr_en_p1;
    logic                  selecao1_p1;
    logic                  selecao2_p1;
    logic [ADDR_WIDTH-1:0] reg_rt_p1;
    logic [ADDR_WIDTH-1:0] reg_rd_p1;
    logic [ADDR_WIDTH-1:0] reg_ra_p1;
    logic [DATA_WIDTH-1:0] wr_dado_p1;

    logic grant_alu;
    logic grant_mem;
    logic accept_alu;
    logic accept_mem;

    function automatic logic [ADDR_WIDTH-1:0] alu_dest_addr(
        input logic [1:0]            dst,
        input logic [ADDR_WIDTH-1:0] rt,
        input logic [ADDR_WIDTH-1:0] rd
    );
        case (dst)
            DST_RT:  alu_dest_addr = rt;
            DST_RD:  alu_dest_addr = rd;
            default: alu_dest_addr = '1;
        endcase
    endfunction

`ifdef ESCRITA_RR_EN
    // Set when the ALU won the most recent contended grant; reset favours mem first.
    logic alu_last;

    always_comb begin
        grant_mem = mem_vld_p0 && (!alu_vld_p0 || alu_last);
        grant_alu = alu_vld_p0 && !grant_mem;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            alu_last <= 1'b1;
        end else if (alu_vld_p0 && mem_vld_p0) begin
            alu_last <= grant_alu;
        end
    end
`else
    always_comb begin
        grant_mem = mem_vld_p0;
        grant_alu = alu_vld_p0 && !mem_vld_p0;
    end
`endif

    // A slot granted this cycle frees up at the same edge, so it can take a new request.
    assign bus.alu_ready = !alu_vld_p0 || grant_alu;
    assign bus.mem_ready = !mem_vld_p0 || grant_mem;

    assign accept_alu = bus.alu_valid && bus.alu_ready && (bus.alu_dst != DST_NONE);
    assign accept_mem = bus.mem_valid && bus.mem_ready;

    // Stage p0: holding slots
    always_ff @(posedge clock) begin
        if (reset) begin
            alu_vld_p0 <= 1'b0;
            mem_vld_p0 <= 1'b0;
        end else begin
            if (accept_alu)     alu_vld_p0 <= 1'b1;
            else if (grant_alu) alu_vld_p0 <= 1'b0;
            if (accept_mem)     mem_vld_p0 <= 1'b1;
            else if (grant_mem) mem_vld_p0 <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (accept_alu) begin
            alu_dst_p0  <= bus.alu_dst;
            alu_rt_p0   <= bus.alu_rt;
            alu_rd_p0   <= bus.alu_rd;
            alu_dado_p0 <= bus.alu_dado;
        end
        if (accept_mem) begin
            mem_rt_p0   <= bus.mem_rt;
            mem_dado_p0 <= bus.mem_dado;
        end
    end

    // Stage p1: registered write port; address 0 consumes the grant without writing
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_en_p1    <= 1'b0;
            selecao1_p1 <= 1'b0;
            selecao2_p1 <= 1'b0;
            reg_rt_p1   <= '0;
            reg_rd_p1   <= '0;
            reg_ra_p1   <= '0;
            wr_dado_p1  <= '0;
        end else if (grant_mem) begin
            wr_en_p1    <= |mem_rt_p0;
            selecao1_p1 <= 1'b0;
            selecao2_p1 <= 1'b0;
            reg_rt_p1   <= mem_rt_p0;
            reg_rd_p1   <= '0;
            reg_ra_p1   <= '1;
            wr_dado_p1  <= mem_dado_p0;
        end else if (grant_alu) begin
            wr_en_p1    <= |alu_dest_addr(alu_dst_p0, alu_rt_p0, alu_rd_p0);
            selecao1_p1 <= (alu_dst_p0 == DST_RD);
            selecao2_p1 <= (alu_dst_p0 == DST_RA);
            reg_rt_p1   <= alu_rt_p0;
            reg_rd_p1   <= alu_rd_p0;
            reg_ra_p1   <= '1;
            wr_dado_p1  <= alu_dado_p0;
        end else begin
            wr_en_p1    <= 1'b0;
            selecao1_p1 <= 1'b0;
            selecao2_p1 <= 1'b0;
            reg_rt_p1   <= '0;
            reg_rd_p1   <= '0;
            reg_ra_p1   <= '0;
            wr_dado_p1  <= '0;
        end
    end

    assign bus.wr_en    = wr_en_p1;
    assign bus.selecao1 = selecao1_p1;
    assign bus.selecao2 = selecao2_p1;
    assign bus.reg_rt   = reg_rt_p1;
    assign bus.reg_rd   = reg_rd_p1;
    assign bus.reg_ra   = reg_ra_p1;
    assign bus.wr_dado  = wr_dado_p1;
endmodule

// File: tb/tb_escrita_reg_arbitro.sv
// Scoreboard bench for escrita_reg_arbitro: stimulus pushes expected writes,
// a negedge monitor pops and compares each wr_en pulse.
module tb_escrita_reg_arbitro;
    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    escrita_reg_arbitro_if #(.DATA_WIDTH(32), .ADDR_WIDTH(6)) bus();

    escrita_reg_arbitro #(.DATA_WIDTH(32), .ADDR_WIDTH(6)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic        s1;
        logic        s2;
        logic [5:0]  rt;
        logic [5:0]  rd;
        logic [31:0] dado;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    function automatic void exp_alu(input string name, input logic [1:0] dst,
                                    input logic [5:0] rt, input logic [5:0] rd,
                                    input logic [31:0] dado);
        exp_t e;
        e.name = name; e.s1 = (dst == 2'b01); e.s2 = (dst == 2'b10);
        e.rt = rt; e.rd = rd; e.dado = dado;
        sb.push_back(e);
    endfunction

    function automatic void exp_mem(input string name, input logic [5:0] rt,
                                    input logic [31:0] dado);
        exp_t e;
        e.name = name; e.s1 = 1'b0; e.s2 = 1'b0;
        e.rt = rt; e.rd = 6'd0; e.dado = dado;
        sb.push_back(e);
    endfunction

    // Monitor: every write pulse must match the head of the scoreboard.
    always @(negedge clock) begin
        if (bus.wr_en === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got wr_en=1 rt=%0d rd=%0d dado=%h, expected no write",
                         bus.reg_rt, bus.reg_rd, bus.wr_dado);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (bus.selecao1 !== e.s1 || bus.selecao2 !== e.s2 || bus.reg_rt !== e.rt ||
                    bus.reg_rd !== e.rd || bus.reg_ra !== 6'h3F || bus.wr_dado !== e.dado) begin
                    errors++;
                    $display("FAIL %s: got sel=%b%b rt=%0d rd=%0d ra=%h dado=%h, expected sel=%b%b rt=%0d rd=%0d ra=3f dado=%h",
                             e.name, bus.selecao1, bus.selecao2, bus.reg_rt, bus.reg_rd, bus.reg_ra,
                             bus.wr_dado, e.s1, e.s2, e.rt, e.rd, e.dado);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drain(input string name, input int limit);
        int n = 0;
        while (sb.size() != 0 && n < limit) begin
            tick();
            n++;
        end
        tick();
        chk(name, 64'(sb.size()), 64'd0);
    endtask

    task automatic alu_req(input logic [1:0] dst, input logic [5:0] rt, input logic [5:0] rd,
                           input logic [31:0] dado);
        bus.alu_valid = 1'b1; bus.alu_dst = dst; bus.alu_rt = rt; bus.alu_rd = rd; bus.alu_dado = dado;
    endtask

    task automatic mem_req(input logic [5:0] rt, input logic [31:0] dado);
        bus.mem_valid = 1'b1; bus.mem_rt = rt; bus.mem_dado = dado;
    endtask

    task automatic clear_inputs();
        bus.alu_valid = 1'b0; bus.alu_dst = 2'b00; bus.alu_rt = '0; bus.alu_rd = '0; bus.alu_dado = '0;
        bus.mem_valid = 1'b0; bus.mem_rt = '0; bus.mem_dado = '0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_wr_en"},    64'(bus.wr_en),    64'd0);
        chk({tag, "_selecao1"}, 64'(bus.selecao1), 64'd0);
        chk({tag, "_selecao2"}, 64'(bus.selecao2), 64'd0);
        chk({tag, "_reg_rt"},   64'(bus.reg_rt),   64'd0);
        chk({tag, "_reg_rd"},   64'(bus.reg_rd),   64'd0);
        chk({tag, "_reg_ra"},   64'(bus.reg_ra),   64'd0);
        chk({tag, "_wr_dado"},  64'(bus.wr_dado),  64'd0);
        chk({tag, "_alu_ready"}, 64'(bus.alu_ready), 64'd1);
        chk({tag, "_mem_ready"}, 64'(bus.mem_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        check_idle_outputs("reset");
        reset = 1'b0;
        tick();

        // ALU write to RD: two-cycle latency, one-cycle pulse
        exp_alu("alu_rd5", 2'b01, 6'd9, 6'd5, 32'hA5A5A5A5);
        alu_req(2'b01, 6'd9, 6'd5, 32'hA5A5A5A5);
        tick();
        clear_inputs();
        chk("latency_no_early_write", 64'(bus.wr_en), 64'd0);
        tick();
        chk("latency_write_cycle", 64'(bus.wr_en), 64'd1);
        chk("latency_sel1", 64'(bus.selecao1), 64'd1);
        tick();
        chk("pulse_one_cycle", 64'(bus.wr_en), 64'd0);
        drain("drain_alu_rd", 10);

        // ALU write to RA, then a no-write request
        exp_alu("alu_ra", 2'b10, 6'd12, 6'd13, 32'h00000100);
        alu_req(2'b10, 6'd12, 6'd13, 32'h00000100);
        tick();
        clear_inputs();
        drain("drain_alu_ra", 10);
        alu_req(2'b11, 6'd7, 6'd8, 32'hFFFF0000);
        chk("dst11_ready_before", 64'(bus.alu_ready), 64'd1);
        tick();
        clear_inputs();
        chk("dst11_ready_after", 64'(bus.alu_ready), 64'd1);
        repeat (3) tick();

        // Conflict 1: mem wins first in both builds
        exp_mem("conflict1_mem", 6'd4, 32'h00000044);
        exp_alu("conflict1_alu", 2'b00, 6'd3, 6'd0, 32'h00000033);
        alu_req(2'b00, 6'd3, 6'd0, 32'h00000033);
        mem_req(6'd4, 32'h00000044);
        tick();
        clear_inputs();
        chk("conflict1_alu_ready_wait", 64'(bus.alu_ready), 64'd0);
        chk("conflict1_mem_ready", 64'(bus.mem_ready), 64'd1);
        tick();
        chk("conflict1_alu_ready_granted", 64'(bus.alu_ready), 64'd1);
        drain("drain_conflict1", 10);

        // Conflict 2: ALU wins under round-robin, mem under fixed priority
`ifdef ESCRITA_RR_EN
        exp_alu("conflict2_alu", 2'b00, 6'd5, 6'd0, 32'h00000055);
        exp_mem("conflict2_mem", 6'd6, 32'h00000066);
`else
        exp_mem("conflict2_mem", 6'd6, 32'h00000066);
        exp_alu("conflict2_alu", 2'b00, 6'd5, 6'd0, 32'h00000055);
`endif
        alu_req(2'b00, 6'd5, 6'd0, 32'h00000055);
        mem_req(6'd6, 32'h00000066);
        tick();
        clear_inputs();
`ifdef ESCRITA_RR_EN
        chk("conflict2_mem_ready_wait", 64'(bus.mem_ready), 64'd0);
        chk("conflict2_alu_ready", 64'(bus.alu_ready), 64'd1);
`else
        chk("conflict2_alu_ready_wait", 64'(bus.alu_ready), 64'd0);
        chk("conflict2_mem_ready", 64'(bus.mem_ready), 64'd1);
`endif
        drain("drain_conflict2", 10);

`ifndef ESCRITA_RR_EN
        // Continuous load traffic starves the ALU under fixed priority
        for (int i = 0; i < 6; i++) exp_mem("starve_mem", 6'(10 + i), 32'hB000_0000 + 32'(i));
        exp_alu("starve_alu", 2'b00, 6'd20, 6'd0, 32'h000000A0);
        alu_req(2'b00, 6'd20, 6'd0, 32'h000000A0);
        mem_req(6'd10, 32'hB000_0000);
        tick();
        bus.alu_valid = 1'b0;
        for (int i = 1; i < 6; i++) begin
            chk("starve_alu_ready", 64'(bus.alu_ready), 64'd0);
            chk("starve_mem_ready", 64'(bus.mem_ready), 64'd1);
            mem_req(6'(10 + i), 32'hB000_0000 + 32'(i));
            tick();
        end
        clear_inputs();
        chk("starve_alu_ready_last", 64'(bus.alu_ready), 64'd0);
        drain("drain_starve", 20);
`endif

        // Load to register 0 consumes a grant without writing
        mem_req(6'd0, 32'hDEADBEEF);
        tick();
        clear_inputs();
        chk("zero_mem_ready_granted", 64'(bus.mem_ready), 64'd1);
        tick();
        chk("zero_no_write", 64'(bus.wr_en), 64'd0);
        chk("zero_mem_ready_after", 64'(bus.mem_ready), 64'd1);
        exp_mem("load_rt7", 6'd7, 32'h00000077);
        mem_req(6'd7, 32'h00000077);
        tick();
        clear_inputs();
        drain("drain_load_rt7", 10);

        // Reset with both slots full discards them
        alu_req(2'b00, 6'd1, 6'd0, 32'h11111111);
        mem_req(6'd2, 32'h22222222);
        tick();
        clear_inputs();
        reset = 1'b1;
        tick();
        check_idle_outputs("midreset");
        reset = 1'b0;
        repeat (4) tick();
        chk("midreset_no_write", 64'(bus.wr_en), 64'd0);
        chk("final_queue_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/escrita_reg_arbitro.md
# escrita_reg_arbitro

Register-file write-port arbiter and destination sequencer. Accepts write-back requests from the ALU path and the load-return path and buffers one request per source. Grants one write per cycle and drives the selecao1/selecao2 controls and RT/RD/RA address fields of the destination-register multiplexer, together with write enable and write data. Sits between execute/memory stages and the register file.

## Interface
- DATA_WIDTH, 32, write-data width
- ADDR_WIDTH, 6, register address width; RA is the last register (all ones)

- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- alu_valid  in  1  ALU write-back request
- alu_ready  out  1  ALU request accepted when alu_valid & alu_ready
- alu_dst  in  2  00=RT, 01=RD, 10=RA, 11=no write
- alu_rt, alu_rd  in  ADDR_WIDTH  instruction RT/RD fields
- alu_dado  in  DATA_WIDTH  ALU result
- mem_valid  in  1  load-return request (destination always RT)
- mem_ready  out  1  load request accepted when mem_valid & mem_ready
- mem_rt  in  ADDR_WIDTH  load destination
- mem_dado  in  DATA_WIDTH  load data
- reg_rt, reg_rd, reg_ra  out  ADDR_WIDTH  address candidates to mux (entrada3, entrada1, entrada2)
- selecao1, selecao2  out  1  mux selects
- wr_en  out  1  register-file write enable
- wr_dado  out  DATA_WIDTH  register-file write data

## Operation
- One holding slot per source (valid bit + fields). Accepted request loads its slot at the accepting edge.
- alu_dst=11: accepted, slot not loaded, no write generated.
- Arbitration each cycle over full slots; winner's slot is cleared and its write registered onto the outputs at the next edge.
- Single full slot: that slot wins. Both full: winner per Configuration.
- Select encoding: RT -> selecao1=0, selecao2=0; RD -> 1,0; RA -> 0,1. Never 1,1.
- Mem writes: reg_rt=mem_rt, RT encoding. reg_rd for mem writes = 0.
- reg_ra constant all ones whenever wr_en=1.
- Resolved destination address 0 (RT/RD = 0): grant consumed, wr_en=0, selects/addresses still driven.
- Ready rule: x_ready = slot empty OR slot granted this cycle (combinational pass-through); back-to-back accepts per source allowed.
- Idle cycle (no grant): wr_en=0; selecao1, selecao2, reg_rt, reg_rd, wr_dado = 0.

## Timing
- Reset values: wr_en=0, selecao1=0, selecao2=0, reg_rt=0, reg_rd=0, reg_ra=0, wr_dado=0; both slots empty; alu_ready=mem_ready=1 in cycle after reset edge; priority pointer = "ALU granted last".
- Latency: accept at edge N -> winning request's outputs valid in cycle after edge N+1 (2 cycles), uncontended.
- Throughput: one register write per cycle total.
- Loser of a conflict keeps its slot; its ready stays 0 until granted.
- Simultaneous accept on both sources with both slots empty: both load; conflict resolved next cycle.
- Reset asserted mid-operation: pending slots discarded, outputs to reset values at that edge; reset dominates valid.
- Outputs change only at clock edges; no combinational path from inputs to wr_en/selects/addresses/data.

## Configuration
- ESCRITA_RR_EN defined: round-robin on conflict; pointer updated only on a contended grant; winner = source not granted at last contended grant.
- ESCRITA_RR_EN undefined: fixed priority, mem always wins conflicts; pointer logic absent; ALU can starve under continuous mem traffic.

## Test plan
- Reset then ALU request dst=RD, rd=5, dado=0xA5A5A5A5 -> 2 cycles later wr_en=1, selecao1=1, selecao2=0, reg_rd=5, wr_dado=0xA5A5A5A5, for one cycle.
- ALU dst=RA, dado=0x100 -> wr_en=1, selecao1=0, selecao2=1, reg_ra=6'h3F; ALU dst=11 -> no wr_en pulse, alu_ready stays 1.
- Both sources accept same cycle (ALU rt=3, mem rt=4) with ESCRITA_RR_EN -> mem written first (pointer reset), ALU next cycle; alu_ready=0 during wait; repeat conflict -> ALU first.
- Same conflict without macro, mem_valid held high with new rt each cycle -> mem written every cycle, ALU never written, alu_ready stays 0.
- Load to rt=0 -> no wr_en pulse, mem_ready returns 1 next cycle; following load rt=7 writes normally.
- Reset asserted while both slots full -> no wr_en after reset edge, all outputs 0, both ready=1.
